itoaer: RTL and testbench
=========================

Name: itoaer

Overview:
- Number-to-text formatter: the output-direction counterpart of the outer interpreter's string-to-number parser.
- Takes a DSZ-bit data-stack value and writes its ASCII image, followed by one trailing space, into byte memory through an 8-bit memory master port starting at a given address.
- Used by the Forth "." word and by HEX/DECIMAL-aware output into the terminal output buffer.
- Sits beside the eForth inner interpreter and is arbitrated onto the shared mb8 bus by the outer interpreter.

Parameters:
- DSZ, 32, data width of the value to convert.
- ASZ, 17, memory address width (128K).
- NDIG, 10, digit-buffer depth; must be >= the decimal digit count of 2^(DSZ-1) (10 for DSZ=32).

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous active-high reset.
- en  input  1  start request; sampled only in IDL.
- hex  input  1  1 = base 16 unsigned, 0 = base 10 signed; latched at start.
- vi  input  DSZ  value to convert; latched at start.
- ai  input  ASZ  first output byte address; latched at start.
- mb_we  output  1  memory write strobe.
- mb_ai  output  ASZ  memory byte address.
- mb_vi  output  8  memory write data.
- bsy  output  1  conversion in progress.
- done  output  1  one-cycle completion pulse.
- len  output  8  bytes written by the last conversion, including sign and trailing space.

Behaviour:
- Reset (rst=1 at posedge): state IDL; bsy=0, done=0, mb_we=0, mb_ai=0, mb_vi=0, len=0; digit buffer emptied.
- Reset mid-operation aborts immediately. No further writes occur. Bytes already written stay in memory; len returns to 0.
- All outputs are driven from registered state only; there is no combinational path from en, vi or hex.
- States: IDL, SGN, DIV, PUT, SPC, DONE.
- IDL: bsy=0. With en=1, latch vi/hex/ai into val/hx/ptr, clear cnt, go to SGN.
- SGN (1 cycle):
  - If !hx and val[DSZ-1]=1: mb_we=1, mb_ai=ptr, mb_vi=8'h2D ('-'); ptr++, cnt++; mag = 0-val, taken as DSZ-bit unsigned, so -2^(DSZ-1) yields 2^(DSZ-1).
  - Otherwise mag = val and no write occurs.
  - Go to DIV.
- DIV, hex mode: 1 cycle per digit. Push mag[3:0] into the digit buffer, then mag >>= 4.
- DIV, decimal mode: DSZ cycles per digit, using restoring division by 10 (one quotient bit per cycle, 4-bit remainder). At the end of each digit, push the remainder and set mag = quotient.
- DIV termination: after each push, if mag==0 go to PUT, else start the next digit. At least one digit is always produced, so value 0 yields "0".
- PUT (1 cycle per digit): pop the most-recently pushed digit d (MSD first). mb_we=1, mb_ai=ptr, mb_vi = d<10 ? 8'h30+d : 8'h41+d-10 (uppercase); ptr++, cnt++. Go to SPC after the last pop.
- SPC (1 cycle): mb_we=1, mb_ai=ptr, mb_vi=8'h20; cnt++. Go to DONE.
- DONE (1 cycle): bsy=0, done=1, len=cnt. Go to IDL. en is ignored in DONE; a still-high en starts a new conversion in the following IDL cycle.
- bsy=1 in SGN, DIV, PUT and SPC. en, vi, hex and ai are don't-care while bsy=1.
- mb_we=0 in every state except write cycles; mb_ai and mb_vi hold their last values when not writing.
- Address arithmetic is modulo 2^ASZ (wraps past 2^ASZ-1 to 0).
- Timing, with the IDL cycle that samples en as cycle 0 and k = digit count:
  - hex: DIV cycles 2..k+1; done at cycle 2k+3.
  - decimal: DIV spans k*DSZ cycles; done at cycle k*DSZ+k+3.
- Digit buffer never overflows, given the NDIG constraint.

Test Plan:
- Zero: hex=0, vi=0, ai=0x100 -> writes '0'(0x30)@0x100 and 0x20@0x101; len=2; done at cycle 36.
- Negative decimal: hex=0, vi=-123, ai=0x200 -> 2D,31,32,33,20 @0x200..0x204; len=5; done at cycle 102.
- Hex ignores sign: hex=1, vi=0xDEADBEEF, ai=0x40 -> "DEADBEEF " @0x40..0x48, no '-'; len=9; done at cycle 19.
- Most-negative value: hex=0, vi=0x80000000 -> "-2147483648 "; len=12; exactly 12 mb_we pulses.
- Address wrap: hex=0, vi=42, ai=0x1FFFE -> '4'@0x1FFFE, '2'@0x1FFFF, ' '@0x00000; len=3.
- Reset mid-DIV and held en:
  - Assert rst during DIV of 99999 -> next cycle bsy=0, mb_we=0, len=0, and no writes thereafter.
  - Separately, hold en=1 through DONE -> a second conversion starts exactly one cycle after done.

Source files
------------

// File: rtl/itoaer.sv
// Number-to-text formatter: writes the ASCII image of a data-stack value plus a
// trailing space into byte memory, in signed decimal or unsigned hex.
module itoaer #(
  parameter int DSZ  = 32,
  parameter int ASZ  = 17,
  parameter int NDIG = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             hex,
  input  logic [DSZ-1:0]   vi,
  input  logic [ASZ-1:0]   ai,
  output logic             mb_we,
  output logic [ASZ-1:0]   mb_ai,
  output logic [7:0]       mb_vi,
  output logic             bsy,
  output logic             done,
  output logic [7:0]       len
);

  localparam int CW = $clog2(NDIG + 1);
  localparam int BW = $clog2(DSZ);
  localparam logic [ASZ-1:0] AONE = 1;
  localparam logic [CW-1:0]  CONE = 1;
  localparam logic [BW-1:0]  BONE = 1;
  localparam logic [BW-1:0]  BLAST = BW'(DSZ - 1);

  typedef enum logic [2:0] {IDL, SGN, DIV, PUT, SPC, DONE} state_t;

  state_t          state, state_nx;
  logic [DSZ-1:0]  val;
  logic            hx;
  logic [ASZ-1:0]  ptr;
  logic [7:0]      cnt;
  logic [DSZ-1:0]  mag;
  logic [3:0]      rem;
  logic [BW-1:0]   bc;
  logic [3:0]      dig [NDIG];
  logic [CW-1:0]   dcnt;
  logic [ASZ-1:0]  hold_ai;
  logic [7:0]      hold_vi;

  logic            neg;
  logic [4:0]      trial;
  logic            qbit;
  logic [3:0]      rem_nx;
  logic [DSZ-1:0]  mag_q;
  logic            last_bit;
  logic [3:0]      top;
  logic [7:0]      top_ch;
  logic            push;
  logic [3:0]      push_d;

  // One restoring-division step by 10: shift the next dividend bit into the
  // remainder and subtract 10 when it fits; the quotient shifts into mag.
  always_comb begin
    neg      = !hx && val[DSZ-1];
    trial    = {rem, mag[DSZ-1]};
    qbit     = (trial >= 5'd10);
    rem_nx   = qbit ? 4'(trial - 5'd10) : trial[3:0];
    mag_q    = {mag[DSZ-2:0], qbit};
    last_bit = (bc == BLAST);
    top      = dig[dcnt - CONE];
    top_ch   = (top < 4'd10) ? (8'h30 + {4'h0, top}) : (8'h37 + {4'h0, top});
    push     = (state == DIV) && (hx || last_bit);
    push_d   = hx ? mag[3:0] : rem_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDL;
    else     state <= state_nx;
  end

  // mb_ai/mb_vi fall back to the last written values when not writing.
  always_comb begin
    state_nx = state;
    mb_we    = 1'b0;
    mb_ai    = hold_ai;
    mb_vi    = hold_vi;
    bsy      = 1'b1;
    done     = 1'b0;
    case (state)
      IDL: begin
        bsy = 1'b0;
        if (en) state_nx = SGN;
      end
      SGN: begin
        if (neg) begin
          mb_we = 1'b1;
          mb_ai = ptr;
          mb_vi = 8'h2D;
        end
        state_nx = DIV;
      end
      DIV: begin
        if (hx) begin
          if ((mag >> 4) == '0) state_nx = PUT;
        end else if (last_bit && mag_q == '0) begin
          state_nx = PUT;
        end
      end
      PUT: begin
        mb_we = 1'b1;
        mb_ai = ptr;
        mb_vi = top_ch;
        if (dcnt == CONE) state_nx = SPC;
      end
      SPC: begin
        mb_we    = 1'b1;
        mb_ai    = ptr;
        mb_vi    = 8'h20;
        state_nx = DONE;
      end
      DONE: begin
        bsy      = 1'b0;
        done     = 1'b1;
        state_nx = IDL;
      end
      default: state_nx = IDL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) dig[dcnt] <= push_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val     <= '0;
      hx      <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
      mag     <= '0;
      rem     <= '0;
      bc      <= '0;
      dcnt    <= '0;
      hold_ai <= '0;
      hold_vi <= '0;
      len     <= '0;
    end else begin
      if (mb_we) begin
        hold_ai <= mb_ai;
        hold_vi <= mb_vi;
      end
      case (state)
        IDL: begin
          if (en) begin
            val  <= vi;
            hx   <= hex;
            ptr  <= ai;
            cnt  <= '0;
            dcnt <= '0;
          end
        end
        SGN: begin
          rem <= '0;
          bc  <= '0;
          if (neg) begin
            mag <= '0 - val;
            ptr <= ptr + AONE;
            cnt <= cnt + 8'd1;
          end else begin
            mag <= val;
          end
        end
        DIV: begin
          if (hx) begin
            mag  <= mag >> 4;
            dcnt <= dcnt + CONE;
          end else if (last_bit) begin
            mag  <= mag_q;
            rem  <= '0;
            bc   <= '0;
            dcnt <= dcnt + CONE;
          end else begin
            mag <= mag_q;
            rem <= rem_nx;
            bc  <= bc + BONE;
          end
        end
        PUT: begin
          ptr  <= ptr + AONE;
          cnt  <= cnt + 8'd1;
          dcnt <= dcnt - CONE;
        end
        SPC: begin
          cnt <= cnt + 8'd1;
          len <= cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_itoaer.sv
// Directed bench for itoaer: logs every memory write and checks bytes,
// addresses, lengths and completion timing against hand-computed values.
module tb_itoaer;

  localparam int DSZ = 32;
  localparam int ASZ = 17;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic            hex = 1'b0;
  logic [DSZ-1:0]  vi  = '0;
  logic [ASZ-1:0]  ai  = '0;
  logic            mb_we;
  logic [ASZ-1:0]  mb_ai;
  logic [7:0]      mb_vi;
  logic            bsy;
  logic            done;
  logic [7:0]      len;

  int checks = 0;
  int passed = 0;

  logic [ASZ-1:0] wa [$];
  logic [7:0]     wd [$];

  itoaer #(.DSZ(DSZ), .ASZ(ASZ), .NDIG(10)) dut (
    .clk(clk), .rst(rst), .en(en), .hex(hex), .vi(vi), .ai(ai),
    .mb_we(mb_we), .mb_ai(mb_ai), .mb_vi(mb_vi),
    .bsy(bsy), .done(done), .len(len)
  );

  always #5 clk = ~clk;

  // Write monitor: one sample per cycle, away from the active edge.
  always @(negedge clk) begin
    if (mb_we === 1'b1) begin
      wa.push_back(mb_ai);
      wd.push_back(mb_vi);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic start_conv(input logic h, input logic [DSZ-1:0] v, input logic [ASZ-1:0] a);
    @(negedge clk);
    wa.delete();
    wd.delete();
    en  = 1'b1;
    hex = h;
    vi  = v;
    ai  = a;
    @(posedge clk);
    #1 en = 1'b0;
  endtask

  // Returns the cycle number of the done pulse (cycle 0 samples en), or -1.
  task automatic wait_done(output int cyc);
    cyc = 1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (done === 1'b1) return;
      @(posedge clk);
      cyc++;
    end
    cyc = -1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bsy, done, mb_we, mb_ai, mb_vi, len} !== '0)
      $display("[TB] FAIL reset_outputs: got bsy=%b done=%b we=%b ai=%h vi=%h len=%0d, want all zero",
               bsy, done, mb_we, mb_ai, mb_vi, len);
    else passed++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bsy !== 1'b0 || mb_we !== 1'b0)
      $display("[TB] FAIL reset_idle: got bsy=%b we=%b, want 0 0", bsy, mb_we);
    else passed++;
  endtask

  task automatic test_zero;
    string exp = "0 ";
    int cyc;
    start_conv(1'b0, 32'd0, 17'h100);
    wait_done(cyc);
    checks++;
    if (cyc !== 36) $display("[TB] FAIL zero_timing: done at cycle %0d, want 36", cyc);
    else passed++;
    checks++;
    if (len !== 8'd2) $display("[TB] FAIL zero_len: got %0d, want 2", len);
    else passed++;
    checks++;
    if (wd.size() !== 2) $display("[TB] FAIL zero_count: got %0d writes, want 2", wd.size());
    else passed++;
    for (int i = 0; i < 2 && i < wd.size(); i++) begin
      checks++;
      if (wd[i] !== exp[i] || wa[i] !== 17'(17'h100 + i))
        $display("[TB] FAIL zero_byte%0d: got %h@%h, want %h@%h", i, wd[i], wa[i], exp[i], 17'(17'h100 + i));
      else passed++;
    end
  endtask

  task automatic test_neg_dec;
    string exp = "-123 ";
    int cyc;
    start_conv(1'b0, -32'sd123, 17'h200);
    wait_done(cyc);
    checks++;
    if (cyc !== 102) $display("[TB] FAIL neg_timing: done at cycle %0d, want 102", cyc);
    else passed++;
    checks++;
    if (len !== 8'd5) $display("[TB] FAIL neg_len: got %0d, want 5", len);
    else passed++;
    checks++;
    if (wd.size() !== 5) $display("[TB] FAIL neg_count: got %0d writes, want 5", wd.size());
    else passed++;
    for (int i = 0; i < 5 && i < wd.size(); i++) begin
      checks++;
      if (wd[i] !== exp[i] || wa[i] !== 17'(17'h200 + i))
        $display("[TB] FAIL neg_byte%0d: got %h@%h, want %h@%h", i, wd[i], wa[i], exp[i], 17'(17'h200 + i));
      else passed++;
    end
  endtask

  task automatic test_hex;
    string exp = "DEADBEEF ";
    int cyc;
    start_conv(1'b1, 32'hDEADBEEF, 17'h40);
    wait_done(cyc);
    checks++;
    if (cyc !== 19) $display("[TB] FAIL hex_timing: done at cycle %0d, want 19", cyc);
    else passed++;
    checks++;
    if (len !== 8'd9) $display("[TB] FAIL hex_len: got %0d, want 9", len);
    else passed++;
    checks++;
    if (wd.size() !== 9) $display("[TB] FAIL hex_count: got %0d writes, want 9", wd.size());
    else passed++;
    for (int i = 0; i < 9 && i < wd.size(); i++) begin
      checks++;
      if (wd[i] !== exp[i] || wa[i] !== 17'(17'h40 + i))
        $display("[TB] FAIL hex_byte%0d: got %h@%h, want %h@%h", i, wd[i], wa[i], exp[i], 17'(17'h40 + i));
      else passed++;
    end
  endtask

  task automatic test_min_neg;
    string exp = "-2147483648 ";
    int cyc;
    start_conv(1'b0, 32'h80000000, 17'h1000);
    wait_done(cyc);
    checks++;
    if (cyc !== 10 * 32 + 10 + 3) $display("[TB] FAIL minneg_timing: done at cycle %0d, want 333", cyc);
    else passed++;
    checks++;
    if (len !== 8'd12) $display("[TB] FAIL minneg_len: got %0d, want 12", len);
    else passed++;
    checks++;
    if (wd.size() !== 12) $display("[TB] FAIL minneg_count: got %0d writes, want 12", wd.size());
    else passed++;
    for (int i = 0; i < 12 && i < wd.size(); i++) begin
      checks++;
      if (wd[i] !== exp[i] || wa[i] !== 17'(17'h1000 + i))
        $display("[TB] FAIL minneg_byte%0d: got %h@%h, want %h@%h", i, wd[i], wa[i], exp[i], 17'(17'h1000 + i));
      else passed++;
    end
  endtask

  task automatic test_wrap;
    logic [ASZ-1:0] ea [3];
    string exp = "42 ";
    int cyc;
    ea[0] = 17'h1FFFE;
    ea[1] = 17'h1FFFF;
    ea[2] = 17'h00000;
    start_conv(1'b0, 32'd42, 17'h1FFFE);
    wait_done(cyc);
    checks++;
    if (len !== 8'd3) $display("[TB] FAIL wrap_len: got %0d, want 3", len);
    else passed++;
    checks++;
    if (wd.size() !== 3) $display("[TB] FAIL wrap_count: got %0d writes, want 3", wd.size());
    else passed++;
    for (int i = 0; i < 3 && i < wd.size(); i++) begin
      checks++;
      if (wd[i] !== exp[i] || wa[i] !== ea[i])
        $display("[TB] FAIL wrap_byte%0d: got %h@%h, want %h@%h", i, wd[i], wa[i], exp[i], ea[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    start_conv(1'b0, 32'd99999, 17'h500);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bsy !== 1'b1) $display("[TB] FAIL midrst_busy: got bsy=%b, want 1", bsy);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bsy !== 1'b0 || mb_we !== 1'b0 || len !== 8'd0)
      $display("[TB] FAIL midrst_abort: got bsy=%b we=%b len=%0d, want 0 0 0", bsy, mb_we, len);
    else passed++;
    rst = 1'b0;
    repeat (300) @(negedge clk);
    checks++;
    if (wd.size() !== 0 || bsy !== 1'b0)
      $display("[TB] FAIL midrst_quiet: got %0d writes bsy=%b, want 0 writes bsy=0", wd.size(), bsy);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    int cyc2;
    @(negedge clk);
    wa.delete();
    wd.delete();
    en  = 1'b1;
    hex = 1'b1;
    vi  = 32'h5;
    ai  = 17'h300;
    @(posedge clk);
    wait_done(cyc);
    checks++;
    if (cyc !== 5) $display("[TB] FAIL b2b_first_timing: done at cycle %0d, want 5", cyc);
    else passed++;
    @(negedge clk);
    checks++;
    if (bsy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL b2b_idle: got bsy=%b done=%b, want 0 0", bsy, done);
    else passed++;
    @(negedge clk);
    checks++;
    if (bsy !== 1'b1) $display("[TB] FAIL b2b_restart: got bsy=%b, want 1", bsy);
    else passed++;
    en = 1'b0;
    wait_done(cyc2);
    checks++;
    if (cyc2 !== 4) $display("[TB] FAIL b2b_second_timing: done %0d cycles after SGN, want 4", cyc2);
    else passed++;
    checks++;
    if (wd.size() !== 4 || wd[0] !== 8'h35 || wd[1] !== 8'h20 || wd[2] !== 8'h35 || wa[2] !== 17'h300)
      $display("[TB] FAIL b2b_writes: got %0d writes first=%h, want 4 writes of 35,20,35,20 from 300",
               wd.size(), (wd.size() > 0) ? wd[0] : 8'h00);
    else passed++;
    checks++;
    if (len !== 8'd2) $display("[TB] FAIL b2b_len: got %0d, want 2", len);
    else passed++;
  endtask

  initial begin
    $display("[TB] starting itoaer bench");
    test_reset();
    test_zero();
    test_neg_dec();
    test_hex();
    test_min_neg();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
